param_updown_counter: RTL and testbench

//  Parametrised modulo-N up/down counter with synchronous parallel load and

---
 rtl/param_updown_counter.sv | 134 +++++++++++++
 tb/tb_param_updown_counter.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/param_updown_counter.sv
// -----------------------------------------------------------------------------
// param_updown_counter
// Parametrised modulo-(MAX_COUNT+1) up/down counter with synchronous parallel
// load (clamped to MAX_COUNT), count enable, terminal-count flag for cascading
// and a registered one-cycle wrap pulse.
//
// Optional feature macro: UDC_STICKY_OVF_EN
//   When defined, adds ovf_clr (in) and ovf_sticky (out, registered). The
//   sticky flag sets on every wrap and clears on ovf_clr. If a set and a clear
//   land on the same edge, the set wins.
// -----------------------------------------------------------------------------
module param_updown_counter #(
  parameter int WIDTH     = 4,
  parameter int MAX_COUNT = (2 ** WIDTH) - 1,
  parameter int RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             reset,      // asynchronous, active-low
  input  logic [WIDTH-1:0] data_in,
  input  logic             load,
  input  logic             en,
  input  logic             up_dn,
`ifdef UDC_STICKY_OVF_EN
  input  logic             ovf_clr,
  output logic             ovf_sticky,
`endif
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] MAX_C  = WIDTH'(MAX_COUNT);
  localparam logic [WIDTH-1:0] RST_C  = WIDTH'(RESET_VAL);
  localparam logic [WIDTH-1:0] ZERO_C = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE_C  = WIDTH'(1'b1);

  // Clamp a load value so the counter never holds a value above MAX_COUNT.
  function automatic logic [WIDTH-1:0] clamp_load(input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] r;
    if (v > MAX_C) begin
      r = MAX_C;
    end else begin
      r = v;
    end
    return r;
  endfunction

  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q,  wrap_d;

  // Next-state selection: load beats enable, enable beats hold.
  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    if (load) begin
      count_d = clamp_load(data_in);
      wrap_d  = 1'b0;
    end else if (en) begin
      case (up_dn)
        1'b1: begin
          if (count_q == MAX_C) begin
            count_d = ZERO_C;
            wrap_d  = 1'b1;
          end else begin
            count_d = count_q + ONE_C;
            wrap_d  = 1'b0;
          end
        end
        1'b0: begin
          if (count_q == ZERO_C) begin
            count_d = MAX_C;
            wrap_d  = 1'b1;
          end else begin
            count_d = count_q - ONE_C;
            wrap_d  = 1'b0;
          end
        end
        default: begin
          count_d = count_q;
          wrap_d  = 1'b0;
        end
      endcase
    end else begin
      count_d = count_q;
      wrap_d  = 1'b0;
    end
  end

  // Count and wrap registers; reset forces them immediately, independent of clk.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= RST_C;
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
    end
  end

  assign count = count_q;
  assign wrap  = wrap_q;

  // Terminal count looks only at the current value and direction, not at en,
  // so it can feed the enable of the next stage in a cascade.
  assign tc = (up_dn & (count_q == MAX_C)) | (~up_dn & (count_q == ZERO_C));

`ifdef UDC_STICKY_OVF_EN
  logic ovf_q, ovf_d;

  // Sticky overflow: a wrap on this edge sets it and overrides a clear.
  always_comb begin
    ovf_d = ovf_q;
    if (wrap_d) begin
      ovf_d = 1'b1;
    end else if (ovf_clr) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // Sticky overflow register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf_sticky = ovf_q;
`endif

endmodule

// File: tb/tb_param_updown_counter.sv
// Directed testbench for param_updown_counter (WIDTH=4, MAX_COUNT=9, RESET_VAL=0).
module tb_param_updown_counter;

  logic       clk;
  logic       reset;
  logic [3:0] data_in;
  logic       load;
  logic       en;
  logic       up_dn;
  logic [3:0] count;
  logic       tc;
  logic       wrap;
`ifdef UDC_STICKY_OVF_EN
  logic       ovf_clr;
  logic       ovf_sticky;
`endif

  int errors = 0;
  int checks = 0;

  param_updown_counter #(.WIDTH(4), .MAX_COUNT(9), .RESET_VAL(0)) dut (
    .clk        (clk),
    .reset      (reset),
    .data_in    (data_in),
    .load       (load),
    .en         (en),
    .up_dn      (up_dn),
`ifdef UDC_STICKY_OVF_EN
    .ovf_clr    (ovf_clr),
    .ovf_sticky (ovf_sticky),
`endif
    .count      (count),
    .tc         (tc),
    .wrap       (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [3:0] v);
    load    = 1'b1;
    en      = 1'b0;
    data_in = v;
    tick();
    load    = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; load = 1'b0; en = 1'b0; up_dn = 1'b1; data_in = 4'd0;
`ifdef UDC_STICKY_OVF_EN
    ovf_clr = 1'b0;
`endif
    tick(); tick();
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", count); end
    checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL reset_wrap: got %0b want 0", wrap); end
    reset = 1'b1;
    tick();
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL reset_hold_idle: got %0d want 0", count); end
    // count up to 5, then pulse reset mid-cycle
    en = 1'b1;
    repeat (5) tick();
    checks++; if (count !== 4'd5) begin errors++; $display("FAIL pre_reset_count: got %0d want 5", count); end
    #1 reset = 1'b0;
    #1;
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL async_reset_count: got %0d want 0", count); end
    checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL async_reset_wrap: got %0b want 0", wrap); end
    #1 reset = 1'b1;
    tick();
    checks++; if (count !== 4'd1) begin errors++; $display("FAIL resume_after_reset: got %0d want 1", count); end
    en = 1'b0;
  endtask

  task automatic test_count_up();
    logic [3:0] exp_c [12] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd0, 4'd1, 4'd2};
    logic       exp_w [12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic       exp_t [12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    do_load(4'd0);
    up_dn = 1'b1;
    en    = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      checks++; if (count !== exp_c[i]) begin errors++; $display("FAIL up_count[%0d]: got %0d want %0d", i, count, exp_c[i]); end
      checks++; if (wrap !== exp_w[i]) begin errors++; $display("FAIL up_wrap[%0d]: got %0b want %0b", i, wrap, exp_w[i]); end
      checks++; if (tc !== exp_t[i]) begin errors++; $display("FAIL up_tc[%0d]: got %0b want %0b", i, tc, exp_t[i]); end
    end
    en = 1'b0;
  endtask

  task automatic test_count_down();
    logic [3:0] exp_c [4] = '{4'd1, 4'd0, 4'd9, 4'd8};
    logic       exp_w [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic       exp_t [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    do_load(4'd2);
    up_dn = 1'b0;
    en    = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (count !== exp_c[i]) begin errors++; $display("FAIL dn_count[%0d]: got %0d want %0d", i, count, exp_c[i]); end
      checks++; if (wrap !== exp_w[i]) begin errors++; $display("FAIL dn_wrap[%0d]: got %0b want %0b", i, wrap, exp_w[i]); end
      checks++; if (tc !== exp_t[i]) begin errors++; $display("FAIL dn_tc[%0d]: got %0b want %0b", i, tc, exp_t[i]); end
    end
    en = 1'b0;
  endtask

  task automatic test_load();
    // load beats en; out-of-range value clamps to 9
    load = 1'b1; en = 1'b1; up_dn = 1'b1; data_in = 4'd13;
    tick();
    checks++; if (count !== 4'd9) begin errors++; $display("FAIL load_clamp13: got %0d want 9", count); end
    checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL load_clamp_wrap: got %0b want 0", wrap); end
    data_in = 4'd4;
    tick();
    checks++; if (count !== 4'd4) begin errors++; $display("FAIL load4: got %0d want 4", count); end
    checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL load4_wrap: got %0b want 0", wrap); end
    data_in = 4'd15;
    tick();
    checks++; if (count !== 4'd9) begin errors++; $display("FAIL load_clamp15: got %0d want 9", count); end
    // a load at 9 with en=1 up must not wrap
    data_in = 4'd9;
    tick();
    checks++; if (count !== 4'd9) begin errors++; $display("FAIL load9_over_en: got %0d want 9", count); end
    checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL load9_wrap: got %0b want 0", wrap); end
    load = 1'b0; en = 1'b0;
  endtask

  task automatic test_hold_and_tc();
    do_load(4'd7);
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (count !== 4'd7) begin errors++; $display("FAIL hold_count[%0d]: got %0d want 7", i, count); end
      checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL hold_wrap[%0d]: got %0b want 0", i, wrap); end
    end
    do_load(4'd9);
    up_dn = 1'b1;
    #1;
    checks++; if (tc !== 1'b1) begin errors++; $display("FAIL tc_up_at9: got %0b want 1", tc); end
    up_dn = 1'b0;
    #1;
    checks++; if (tc !== 1'b0) begin errors++; $display("FAIL tc_dn_at9: got %0b want 0", tc); end
    checks++; if (count !== 4'd9) begin errors++; $display("FAIL tc_flip_count: got %0d want 9", count); end
    // wrap then disable: wrap must drop after one cycle
    up_dn = 1'b1; en = 1'b1;
    tick();
    en = 1'b0;
    checks++; if (wrap !== 1'b1) begin errors++; $display("FAIL wrap_pulse: got %0b want 1", wrap); end
    tick();
    checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL wrap_drop_hold: got %0b want 0", wrap); end
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL wrap_hold_count: got %0d want 0", count); end
  endtask

  task automatic test_back_to_back();
    do_load(4'd5);
    en = 1'b1; up_dn = 1'b1;
    tick();
    checks++; if (count !== 4'd6) begin errors++; $display("FAIL b2b_up: got %0d want 6", count); end
    up_dn = 1'b0;
    tick();
    checks++; if (count !== 4'd5) begin errors++; $display("FAIL b2b_dn: got %0d want 5", count); end
    up_dn = 1'b1;
    tick();
    checks++; if (count !== 4'd6) begin errors++; $display("FAIL b2b_up2: got %0d want 6", count); end
    en = 1'b0;
  endtask

`ifdef UDC_STICKY_OVF_EN
  task automatic test_sticky();
    ovf_clr = 1'b1; en = 1'b0;
    tick();
    ovf_clr = 1'b0;
    checks++; if (ovf_sticky !== 1'b0) begin errors++; $display("FAIL sticky_clear0: got %0b want 0", ovf_sticky); end
    do_load(4'd9);
    up_dn = 1'b1; en = 1'b1;
    tick();
    en = 1'b0;
    checks++; if (ovf_sticky !== 1'b1) begin errors++; $display("FAIL sticky_set: got %0b want 1", ovf_sticky); end
    do_load(4'd9);
    checks++; if (ovf_sticky !== 1'b1) begin errors++; $display("FAIL sticky_load: got %0b want 1", ovf_sticky); end
    en = 1'b1; ovf_clr = 1'b1;
    tick();
    en = 1'b0;
    checks++; if (ovf_sticky !== 1'b1) begin errors++; $display("FAIL sticky_set_wins: got %0b want 1", ovf_sticky); end
    tick();
    ovf_clr = 1'b0;
    checks++; if (ovf_sticky !== 1'b0) begin errors++; $display("FAIL sticky_clear: got %0b want 0", ovf_sticky); end
  endtask
`endif

  initial begin
    test_reset();
    test_count_up();
    test_count_down();
    test_load();
    test_hold_and_tc();
    test_back_to_back();
`ifdef UDC_STICKY_OVF_EN
    test_sticky();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
